// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the I/D-cache to unified-memory arbiter.
package mem_arb_pkg;

  localparam int LINE_W      = 64;
  localparam int LADDR_W     = 14;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester that received the most recent completed grant
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave = arbiter, master = caches plus memory.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                   i_req;
  logic [LADDR_W-1:0]     i_addr;
  logic                   i_rdy;
  logic [LINE_W-1:0]      i_rdata;

  logic                   d_req;
  logic                   d_we;
  logic [LADDR_W-1:0]     d_addr;
  logic [LINE_W-1:0]      d_wdata;
  logic                   d_rdy;
  logic [LINE_W-1:0]      d_rdata;

  logic                   mem_re;
  logic                   mem_we;
  logic [LADDR_W-1:0]     mem_addr;
  logic [LINE_W-1:0]      mem_wdata;
  logic [LINE_W-1:0]      mem_rdata;
  logic                   mem_rdy;

  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    output stall, stall_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata,
    input  stall, stall_cnt
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of I-cache and D-cache line requests onto one memory port.
// Strobes one cycle after a request is sampled; x_rdy one cycle after mem_rdy; requesters wait via stall.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  gnt_t                   r_last_gnt;

  logic                   r_mem_re;
  logic                   r_mem_we;
  logic [LADDR_W-1:0]     r_mem_addr;
  logic [LINE_W-1:0]      r_mem_wdata;
  logic                   r_i_rdy;
  logic                   r_d_rdy;
  logic [LINE_W-1:0]      r_i_rdata;
  logic [LINE_W-1:0]      r_d_rdata;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_mem_re_nxt;
  logic                   w_mem_we_nxt;
  logic [LADDR_W-1:0]     w_mem_addr_nxt;
  logic [LINE_W-1:0]      w_mem_wdata_nxt;
  logic                   w_i_rdy_nxt;
  logic                   w_d_rdy_nxt;
  logic                   w_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On a tie the requester that did not win last time is granted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req && bus.d_req) begin
          w_state_nxt = (r_last_gnt == GNT_I) ? ST_GNT_D : ST_GNT_I;
        end else if (bus.i_req) begin
          w_state_nxt = ST_GNT_I;
        end else if (bus.d_req) begin
          w_state_nxt = ST_GNT_D;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (bus.mem_rdy) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered memory-side and ready outputs
  always_comb begin
    w_mem_re_nxt    = r_mem_re;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_i_rdy_nxt     = 1'b0;
    w_d_rdy_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_state_nxt == ST_GNT_I) begin
          w_mem_re_nxt    = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = bus.i_addr;
          w_mem_wdata_nxt = '0;
        end else if (w_state_nxt == ST_GNT_D) begin
          w_mem_re_nxt    = ~bus.d_we;
          w_mem_we_nxt    = bus.d_we;
          w_mem_addr_nxt  = bus.d_addr;
          w_mem_wdata_nxt = bus.d_we ? bus.d_wdata : '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (bus.mem_rdy) begin
          w_mem_re_nxt    = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
          w_i_rdy_nxt     = (r_state == ST_GNT_I);
          w_d_rdy_nxt     = (r_state == ST_GNT_D);
        end
      end
      default: begin
      end
    endcase
  end

  assign w_stall = (bus.i_req | bus.d_req) & (r_state != ST_RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_gnt  <= GNT_I;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdy     <= 1'b0;
      r_d_rdy     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mem_re    <= w_mem_re_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_i_rdy     <= w_i_rdy_nxt;
      r_d_rdy     <= w_d_rdy_nxt;
      if (bus.mem_rdy && (r_state == ST_GNT_I)) begin
        r_i_rdata  <= bus.mem_rdata;
        r_last_gnt <= GNT_I;
      end
      // The registered write strobe tells a D write-back from a D fill
      if (bus.mem_rdy && (r_state == ST_GNT_D)) begin
        if (!r_mem_we) begin
          r_d_rdata <= bus.mem_rdata;
        end
        r_last_gnt <= GNT_D;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_rdy     = r_i_rdy;
  assign bus.d_rdy     = r_d_rdy;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall     = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: requester tasks queue expected responses, a memory responder checks grants, a monitor checks outputs.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [63:0] data;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        exp_i[$];
  exp_t        exp_d[$];
  logic [63:0] mem_arr[16384];
  logic [63:0] ref_arr[16384];
  bit          grant_log[$];
  int          mem_dly = -1;
  bit          mem_hold = 1'b0;
  int          spur_cnt = 0;
  bit          fired_i = 1'b0;
  bit          fired_d = 1'b0;
  bit          last_i_mdl = 1'b1;
  int unsigned m_cnt = 0;
  logic        seen_i_req = 1'b0;
  logic        seen_d_req = 1'b0;
  logic        seen_d_we = 1'b0;
  logic [13:0] seen_i_addr = '0;
  logic [13:0] seen_d_addr = '0;
  logic [63:0] seen_d_wdata = '0;

  function automatic logic [63:0] pat(input int a);
    if (a == 16) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {16'hC0DE, 2'b00, 14'(a), 32'(a) ^ 32'h5A5A_0F0F};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_re", 64'(bus.mem_re), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_i_rdy", 64'(bus.i_rdy), 64'(0));
    chk("rst_d_rdy", 64'(bus.d_rdy), 64'(0));
    chk("rst_i_rdata", bus.i_rdata, 64'(0));
    chk("rst_d_rdata", bus.d_rdata, 64'(0));
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Leaves i_req high; the caller decides whether to drop it
  task automatic req_i(input logic [13:0] a);
    bit got = 1'b0;
    exp_i.push_back('{we: 1'b0, data: ref_arr[a]});
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      got = bus.i_rdy;
    end
    chk("i_rdy_timeout", 64'(got), 64'(1));
  endtask

  task automatic req_d(input logic [13:0] a, input logic we, input logic [63:0] wd);
    bit got = 1'b0;
    if (we) begin
      ref_arr[a] = wd;
      exp_d.push_back('{we: 1'b1, data: 64'(0)});
    end else begin
      exp_d.push_back('{we: 1'b0, data: ref_arr[a]});
    end
    bus.d_addr  = a;
    bus.d_we    = we;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      got = bus.d_rdy;
    end
    chk("d_rdy_timeout", 64'(got), 64'(1));
  endtask

  // Memory model: checks every new grant against the round-robin rule, answers after a delay
  initial begin : responder
    bit          busy;
    int          cnt;
    int          spur_done;
    logic [13:0] ga;
    logic        gre;
    logic        gwe;
    logic [63:0] gwd;
    bit          gi;
    bit          want_i;
    busy = 1'b0;
    cnt = 0;
    spur_done = 0;
    ga = '0;
    gre = 1'b0;
    gwe = 1'b0;
    gwd = '0;
    gi = 1'b0;
    for (int a = 0; a < 16384; a++) mem_arr[a] = pat(a);
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rdy   = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      fired_i = 1'b0;
      fired_d = 1'b0;
      if (!rst) last_i_mdl = 1'b1;
      if (!busy) begin
        if (bus.mem_re || bus.mem_we) begin
          gi     = (bus.mem_addr < 14'h1000);
          want_i = seen_i_req && !(seen_d_req && last_i_mdl);
          chk("grant_had_req", 64'(seen_i_req | seen_d_req), 64'(1));
          chk("grant_winner", 64'(gi), 64'(want_i));
          if (want_i) begin
            chk("i_strobes", 64'({bus.mem_re, bus.mem_we}), 64'(2'b10));
            chk("i_mem_addr", 64'(bus.mem_addr), 64'(seen_i_addr));
            chk("i_mem_wdata", bus.mem_wdata, 64'(0));
          end else begin
            chk("d_strobes", 64'({bus.mem_re, bus.mem_we}), 64'({~seen_d_we, seen_d_we}));
            chk("d_mem_addr", 64'(bus.mem_addr), 64'(seen_d_addr));
            chk("d_mem_wdata", bus.mem_wdata, seen_d_we ? seen_d_wdata : 64'(0));
          end
          grant_log.push_back(gi);
          ga   = bus.mem_addr;
          gre  = bus.mem_re;
          gwe  = bus.mem_we;
          gwd  = bus.mem_wdata;
          busy = 1'b1;
          cnt  = (mem_dly < 0) ? int'($urandom_range(0, 3)) : mem_dly;
        end else if (spur_cnt != spur_done) begin
          bus.mem_rdy = 1'b1;
          spur_done++;
        end
      end else if (!(bus.mem_re || bus.mem_we)) begin
        busy = 1'b0;
      end else begin
        chk("hold_ctl", 64'({bus.mem_re, bus.mem_we, bus.mem_addr}), 64'({gre, gwe, ga}));
        chk("hold_wdata", bus.mem_wdata, gwd);
        cnt--;
      end
      if (busy && !mem_hold && cnt <= 0) begin
        bus.mem_rdy = 1'b1;
        if (gwe) mem_arr[ga] = gwd;
        if (gre) bus.mem_rdata = mem_arr[ga];
        fired_i    = gi;
        fired_d    = !gi;
        last_i_mdl = gi;
        busy       = 1'b0;
      end
    end
  end

  // Output monitor: ready pulses, held read data, stall and its saturating counter
  initial begin : monitor
    logic [63:0] m_ir;
    logic [63:0] m_dr;
    bit          exp_ri;
    bit          exp_rd;
    bit          w_st;
    exp_t        e;
    m_ir = '0;
    m_dr = '0;
    exp_ri = 1'b0;
    exp_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_ir = '0;
        m_dr = '0;
        m_cnt = 0;
        exp_ri = 1'b0;
        exp_rd = 1'b0;
        exp_i.delete();
        exp_d.delete();
      end else begin
        chk("i_rdy", 64'(bus.i_rdy), 64'(exp_ri));
        chk("d_rdy", 64'(bus.d_rdy), 64'(exp_rd));
        if (exp_ri) begin
          if (exp_i.size() == 0) chk("i_scoreboard_depth", 64'(exp_i.size()), 64'(1));
          else begin
            e = exp_i.pop_front();
            m_ir = e.data;
          end
        end
        if (exp_rd) begin
          if (exp_d.size() == 0) chk("d_scoreboard_depth", 64'(exp_d.size()), 64'(1));
          else begin
            e = exp_d.pop_front();
            if (!e.we) m_dr = e.data;
          end
        end
        chk("i_rdata", bus.i_rdata, m_ir);
        chk("d_rdata", bus.d_rdata, m_dr);
        w_st = (bus.i_req || bus.d_req) && !(exp_ri || exp_rd);
        chk("stall", 64'(bus.stall), 64'(w_st));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
        if (w_st && m_cnt < 32'hFFFF) m_cnt++;
        exp_ri = fired_i;
        exp_rd = fired_d;
      end
      seen_i_req   = bus.i_req;
      seen_d_req   = bus.d_req;
      seen_d_we    = bus.d_we;
      seen_i_addr  = bus.i_addr;
      seen_d_addr  = bus.d_addr;
      seen_d_wdata = bus.d_wdata;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int lat;
    bit got;
    for (int a = 0; a < 16384; a++) ref_arr[a] = pat(a);
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    reset_dut();

    // Single I fill, memory answers three cycles after the strobe rises
    mem_dly = 3;
    exp_i.push_back('{we: 1'b0, data: ref_arr[16]});
    bus.i_addr = 14'h0010;
    bus.i_req  = 1'b1;
    @(posedge clk);
    #1;
    chk("strobe_latency", 64'(bus.mem_re), 64'(1));
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      got = bus.i_rdy;
      if (got) lat = k;
    end
    chk("i_rdy_latency", 64'(lat), 64'(3));
    bus.i_req = 1'b0;
    wait_cycles(3);
    chk("i_queue_drained", 64'(exp_i.size()), 64'(0));
    mem_dly = -1;

    // Simultaneous requests after reset: D write-back first, then I
    reset_dut();
    base = grant_log.size();
    fork
      begin req_d(14'h1020, 1'b1, 64'h1234); bus.d_req = 1'b0; end
      begin req_i(14'h0020); bus.i_req = 1'b0; end
    join
    wait_cycles(2);
    chk("tie_grants", 64'(grant_log.size() - base), 64'(2));
    if (grant_log.size() >= base + 2) begin
      chk("tie_first_d", 64'(grant_log[base]), 64'(0));
      chk("tie_second_i", 64'(grant_log[base+1]), 64'(1));
    end

    // Both held continuously: grants alternate D, I, D, I
    reset_dut();
    base = grant_log.size();
    fork
      begin
        repeat (2) req_d(14'(14'h1000 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
        bus.d_req = 1'b0;
      end
      begin
        repeat (2) req_i(14'($urandom_range(0, 255)));
        bus.i_req = 1'b0;
      end
    join
    wait_cycles(2);
    chk("rr_grants", 64'(grant_log.size() - base), 64'(4));
    if (grant_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", 64'(grant_log[base+k]), 64'(k % 2));
    end

    // mem_rdy while idle is ignored; a later request still works
    spur_cnt++;
    wait_cycles(5);
    chk("idle_strobes", 64'({bus.mem_re, bus.mem_we}), 64'(0));
    req_i(14'h0040);
    bus.i_req = 1'b0;
    wait_cycles(2);

    // Random traffic with random memory latency
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          req_i(14'($urandom_range(0, 255)));
          if ($urandom_range(0, 1) == 1) begin
            bus.i_req = 1'b0;
            wait_cycles(int'($urandom_range(1, 3)));
          end
        end
        bus.i_req = 1'b0;
      end
      begin
        for (int k = 0; k < 24; k++) begin
          req_d(14'(14'h1000 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
          if ($urandom_range(0, 1) == 1) begin
            bus.d_req = 1'b0;
            wait_cycles(int'($urandom_range(1, 3)));
          end
        end
        bus.d_req = 1'b0;
      end
    join
    wait_cycles(3);
    chk("rand_i_drained", 64'(exp_i.size()), 64'(0));
    chk("rand_d_drained", 64'(exp_d.size()), 64'(0));

    // Reset during a D grant abandons it; last grant returns to I
    req_d(14'h1003, 1'b1, 64'hFEED_0000_0000_1003);
    bus.d_req = 1'b0;
    wait_cycles(2);
    mem_hold = 1'b1;
    exp_d.push_back('{we: 1'b0, data: ref_arr[14'h1005]});
    bus.d_addr = 14'h1005;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      got = bus.mem_re | bus.mem_we;
    end
    chk("abort_grant_seen", 64'(got), 64'(1));
    reset_dut();
    mem_hold = 1'b0;
    spur_cnt++;
    wait_cycles(5);
    base = grant_log.size();
    fork
      begin req_d(14'h1003, 1'b0, 64'(0)); bus.d_req = 1'b0; end
      begin req_i(14'h0050); bus.i_req = 1'b0; end
    join
    wait_cycles(2);
    chk("post_rst_grants", 64'(grant_log.size() - base), 64'(2));
    if (grant_log.size() >= base + 2) chk("post_rst_tie_d", 64'(grant_log[base]), 64'(0));

    // Stall counter saturation with a request that never completes
    mem_hold   = 1'b1;
    bus.i_addr = 14'h0030;
    bus.i_req  = 1'b1;
    for (int k = 0; k < 70000 && m_cnt < 32'hFFFE; k++) @(posedge clk);
    wait_cycles(5);
    chk("stall_cnt_sat", 64'(bus.stall_cnt), 64'(16'hFFFF));
    reset_dut();
    mem_hold = 1'b0;
    wait_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
